// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer: holds requests until accepted, applies EX redirects, flushes IF/ID.
// Optional statistics counters are built only when REDIRECT_STATS_EN is defined.
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] jal_target,
    input  logic [31:0] alu_target,
    input  logic        stall,
    input  logic        fetch_ready,
    output logic [31:0] pc,
    output logic        fetch_valid,
    output logic        flush,
    output logic [31:0] redirect_cnt,
    output logic [31:0] bubble_cnt
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        PEND,
        BUBBLE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic        hold_q, hold_d;
    logic        kill_q, kill_d;
    logic        redirect_now;
    logic        accept;
    logic [31:0] raw_target;
    logic [31:0] target;

    assign redirect_now = ex_valid && (pc_sel != 2'b00) && (state_q != BOOT);
    assign raw_target   = (pc_sel == 2'b01) ? jal_target : alu_target;
    assign target       = raw_target & 32'hFFFF_FFFC;

    always_comb begin
        fetch_valid = 1'b0;
        unique case (state_q)
            RUN:     fetch_valid = !stall || hold_q;
            PEND:    fetch_valid = 1'b1;
            default: fetch_valid = 1'b0;
        endcase
    end

    assign accept = fetch_valid && fetch_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        hold_d  = fetch_valid && !fetch_ready;
        kill_d  = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (redirect_now) begin
                    kill_d = accept;
                    if (fetch_valid && !fetch_ready) begin
                        pend_d  = target;
                        state_d = PEND;
                    end else begin
                        pc_d    = target;
                        state_d = BUBBLE;
                    end
                end else if (accept) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            PEND: begin
                // newest redirect wins, even over a same-cycle acceptance
                if (redirect_now) begin
                    pend_d = target;
                    kill_d = accept;
                end else if (fetch_ready) begin
                    pc_d    = pend_q;
                    kill_d  = 1'b1;
                    state_d = BUBBLE;
                end
            end
            BUBBLE: begin
                if (redirect_now) begin
                    pc_d = target;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            pend_q  <= 32'd0;
            hold_q  <= 1'b0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            hold_q  <= hold_d;
            kill_q  <= kill_d;
        end
    end

    assign pc    = pc_q;
    assign flush = redirect_now || kill_q;

`ifdef REDIRECT_STATS_EN
    logic [31:0] rcnt_q;
    logic [31:0] bcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt_q <= 32'd0;
            bcnt_q <= 32'd0;
        end else begin
            if (redirect_now && (rcnt_q != 32'hFFFF_FFFF)) begin
                rcnt_q <= rcnt_q + 32'd1;
            end
            if ((state_q == BUBBLE) && (bcnt_q != 32'hFFFF_FFFF)) begin
                bcnt_q <= bcnt_q + 32'd1;
            end
        end
    end

    assign redirect_cnt = rcnt_q;
    assign bubble_cnt   = bcnt_q;
`else
    assign redirect_cnt = 32'd0;
    assign bubble_cnt   = 32'd0;
`endif

endmodule
